// File: rtl/hazard_ctrl_unit.sv
// Hazard, forwarding and stall controller for the 5-stage pipeline: operand
// forwarding, load-use and mult/div interlocks, memory-wait freeze, IF flush, stall counter.
module hazard_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 16,
  parameter int DELAY_SLOT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] e_rn,
  input  logic [REG_AW-1:0] m_rn,
  input  logic              e_wreg,
  input  logic              m_wreg,
  input  logic              e_m2reg,
  input  logic              m_m2reg,
  input  logic              m_mem,
  input  logic              dmem_ready,
  input  logic              id_md_start,
  input  logic              id_md_read,
  input  logic              id_branch_taken,
  input  logic              stat_clr,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              wpcir,
  output logic              bubble,
  output logic              freeze,
  output logic              flush_if,
  output logic              md_busy,
  output logic              md_done,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int MD_CW = $clog2(MD_LAT) + 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       md_state;
  logic [MD_CW-1:0] md_cnt;

  logic e_fwd_ok, m_fwd_ok;
  logic lu_stall, md_stall, issue;

  // EX can only forward ALU results; a load in EX is handled by the load-use stall.
  assign e_fwd_ok = e_wreg & (e_rn != '0) & ~e_m2reg;
  assign m_fwd_ok = m_wreg & (m_rn != '0);

  always_comb begin
    fwda = 2'b00;
    if (e_fwd_ok && (e_rn == id_rs))      fwda = 2'b01;
    else if (m_fwd_ok && (m_rn == id_rs)) fwda = m_m2reg ? 2'b11 : 2'b10;
  end

  always_comb begin
    fwdb = 2'b00;
    if (e_fwd_ok && (e_rn == id_rt))      fwdb = 2'b01;
    else if (m_fwd_ok && (m_rn == id_rt)) fwdb = m_m2reg ? 2'b11 : 2'b10;
  end

  assign lu_stall = e_wreg & e_m2reg & (e_rn != '0) &
                    ((id_use_rs & (e_rn == id_rs)) | (id_use_rt & (e_rn == id_rt)));

  assign md_busy  = (md_state == ST_BUSY);
  assign md_stall = md_busy & (id_md_start | id_md_read);
  assign freeze   = m_mem & ~dmem_ready;
  assign wpcir    = ~(freeze | lu_stall | md_stall);
  assign bubble   = ~freeze & (lu_stall | md_stall);
  assign issue    = wpcir;
  // A stalled branch re-resolves next cycle, so only flush when it actually issues.
  assign flush_if = (DELAY_SLOT == 0) & id_branch_taken & issue;

  // The mult/div unit keeps counting through freeze cycles; only new starts wait on issue.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      md_state <= ST_IDLE;
      md_cnt   <= '0;
      md_done  <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (md_state)
        ST_IDLE: begin
          if (id_md_start && issue) begin
            md_state <= ST_BUSY;
            md_cnt   <= MD_CW'(MD_LAT - 1);
          end
        end
        default: begin
          if (md_cnt == '0) begin
            md_state <= ST_IDLE;
            md_done  <= 1'b1;
          end else begin
            md_cnt <= md_cnt - MD_CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if (stat_clr) begin
      stall_cycles <= '0;
    end else if (!wpcir && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: per-cycle expected outputs from a cycle-indexed
// reference model are queued by the driver and popped by a negedge monitor.
module tb_hazard_ctrl_unit;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int EW     = 10 + CNT_W;

  logic              clock, resetn;
  logic [REG_AW-1:0] id_rs, id_rt, e_rn, m_rn;
  logic id_use_rs, id_use_rt, e_wreg, m_wreg, e_m2reg, m_m2reg;
  logic m_mem, dmem_ready, id_md_start, id_md_read, id_branch_taken, stat_clr;

  logic [1:0]       fwda0, fwdb0, fwda1, fwdb1;
  logic             wpcir0, bubble0, freeze0, flush0, busy0, done0;
  logic             wpcir1, bubble1, freeze1, flush1, busy1, done1;
  logic [CNT_W-1:0] stall0, stall1;

  hazard_ctrl_unit #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W), .DELAY_SLOT(0)) u_flush (
    .clock(clock), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .e_rn(e_rn), .m_rn(m_rn),
    .e_wreg(e_wreg), .m_wreg(m_wreg), .e_m2reg(e_m2reg), .m_m2reg(m_m2reg),
    .m_mem(m_mem), .dmem_ready(dmem_ready), .id_md_start(id_md_start),
    .id_md_read(id_md_read), .id_branch_taken(id_branch_taken), .stat_clr(stat_clr),
    .fwda(fwda0), .fwdb(fwdb0), .wpcir(wpcir0), .bubble(bubble0), .freeze(freeze0),
    .flush_if(flush0), .md_busy(busy0), .md_done(done0), .stall_cycles(stall0));

  hazard_ctrl_unit #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W), .DELAY_SLOT(1)) u_slot (
    .clock(clock), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .e_rn(e_rn), .m_rn(m_rn),
    .e_wreg(e_wreg), .m_wreg(m_wreg), .e_m2reg(e_m2reg), .m_m2reg(m_m2reg),
    .m_mem(m_mem), .dmem_ready(dmem_ready), .id_md_start(id_md_start),
    .id_md_read(id_md_read), .id_branch_taken(id_branch_taken), .stat_clr(stat_clr),
    .fwda(fwda1), .fwdb(fwdb1), .wpcir(wpcir1), .bubble(bubble1), .freeze(freeze1),
    .flush_if(flush1), .md_busy(busy1), .md_done(done1), .stall_cycles(stall1));

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;           // cycle index of the cycle currently being driven
  int md_s = -1000;      // cycle in which the last mult/div start was accepted
  int cnt = 0;           // stall cycle count
  bit cur_wp, cur_busy;
  logic [EW-1:0] exp_q[$];

  function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] src);
    if (e_wreg && e_rn != 0 && e_rn == src && !e_m2reg) return 2'd1;
    if (m_wreg && m_rn != 0 && m_rn == src) return m_m2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic push_exp();
    bit busy, done, lu, frz, mds, wp;
    busy = (cyc >= md_s + 1) && (cyc <= md_s + MD_LAT);
    done = (cyc == md_s + MD_LAT + 1);
    lu   = e_wreg && e_m2reg && e_rn != 0 &&
           ((id_use_rs && e_rn == id_rs) || (id_use_rt && e_rn == id_rt));
    frz  = m_mem && !dmem_ready;
    mds  = busy && (id_md_start || id_md_read);
    wp   = !(frz || lu || mds);
    cur_wp   = wp;
    cur_busy = busy;
    exp_q.push_back({ref_fwd(id_rs), ref_fwd(id_rt), wp, !frz && (lu || mds), frz,
                     id_branch_taken && wp, busy, done, CNT_W'(cnt)});
  endtask

  task automatic model_edge();
    if (resetn) begin
      if (!cur_wp) cnt = (cnt == CMAX) ? CMAX : cnt + 1;
      if (stat_clr) cnt = 0;
      if (!cur_busy && id_md_start && cur_wp) md_s = cyc;
    end
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; e_rn = '0; m_rn = '0;
    id_use_rs = 0; id_use_rt = 0; e_wreg = 0; m_wreg = 0; e_m2reg = 0; m_m2reg = 0;
    m_mem = 0; dmem_ready = 1; id_md_start = 0; id_md_read = 0;
    id_branch_taken = 0; stat_clr = 0;
  endtask

  task automatic next();
    @(posedge clock);
    #1;
    model_edge();
    idle_inputs();
  endtask

  task automatic set_lu();
    e_rn = 5'd5; e_wreg = 1; e_m2reg = 1; id_rt = 5'd5; id_use_rt = 1;
  endtask

  task automatic rand_inputs();
    id_rs = REG_AW'($urandom_range(0, 3)); id_rt = REG_AW'($urandom_range(0, 3));
    e_rn  = REG_AW'($urandom_range(0, 3)); m_rn  = REG_AW'($urandom_range(0, 3));
    id_use_rs = 1'($urandom_range(0, 1)); id_use_rt = 1'($urandom_range(0, 1));
    e_wreg = 1'($urandom_range(0, 1)); m_wreg = 1'($urandom_range(0, 1));
    e_m2reg = ($urandom_range(0, 2) == 0); m_m2reg = 1'($urandom_range(0, 1));
    m_mem = ($urandom_range(0, 3) == 0); dmem_ready = 1'($urandom_range(0, 1));
    id_md_start = ($urandom_range(0, 5) == 0); id_md_read = ($urandom_range(0, 4) == 0);
    id_branch_taken = 1'($urandom_range(0, 1)); stat_clr = ($urandom_range(0, 15) == 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fwda", fwda0, e[EW-1-:2]);          chk("fwda_ds", fwda1, e[EW-1-:2]);
      chk("fwdb", fwdb0, e[EW-3-:2]);          chk("fwdb_ds", fwdb1, e[EW-3-:2]);
      chk("wpcir", wpcir0, e[CNT_W+5]);        chk("wpcir_ds", wpcir1, e[CNT_W+5]);
      chk("bubble", bubble0, e[CNT_W+4]);      chk("bubble_ds", bubble1, e[CNT_W+4]);
      chk("freeze", freeze0, e[CNT_W+3]);      chk("freeze_ds", freeze1, e[CNT_W+3]);
      chk("flush_if", flush0, e[CNT_W+2]);     chk("flush_if_ds", flush1, 0);
      chk("md_busy", busy0, e[CNT_W+1]);       chk("md_busy_ds", busy1, e[CNT_W+1]);
      chk("md_done", done0, e[CNT_W]);         chk("md_done_ds", done1, e[CNT_W]);
      chk("stall_cycles", stall0, e[CNT_W-1:0]);
      chk("stall_cycles_ds", stall1, e[CNT_W-1:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn = 0;
    idle_inputs();
    next(); push_exp();                        // reset state
    next(); resetn = 1; push_exp();

    // forward priority
    next(); id_rs = 3; e_rn = 3; e_wreg = 1; m_rn = 3; m_wreg = 1; push_exp();
    next(); id_rs = 3; e_rn = 3; m_rn = 3; m_wreg = 1; push_exp();
    next(); id_rs = 3; e_rn = 3; m_rn = 3; m_wreg = 1; m_m2reg = 1; push_exp();
    next(); e_wreg = 1; m_wreg = 1; m_m2reg = 1; push_exp();
    next(); id_rt = 7; e_rn = 7; e_wreg = 1; e_m2reg = 1; m_rn = 7; m_wreg = 1; push_exp();

    // load-use, with and without the register actually read
    next(); set_lu(); push_exp();
    next(); set_lu(); id_use_rt = 0; push_exp();

    // mult/div latency with a waiting reader
    next(); id_md_start = 1; push_exp();
    next(); push_exp();
    repeat (4) begin next(); id_md_read = 1; push_exp(); end
    next(); push_exp();

    // freeze during a load-use hazard while mult/div runs
    next(); id_md_start = 1; push_exp();
    repeat (3) begin next(); set_lu(); m_mem = 1; dmem_ready = 0; push_exp(); end
    repeat (3) begin next(); push_exp(); end

    // branch flush with and without a stall
    next(); id_branch_taken = 1; push_exp();
    next(); id_branch_taken = 1; set_lu(); push_exp();

    // counter saturation and clear
    next(); stat_clr = 1; push_exp();
    repeat (20) begin next(); set_lu(); push_exp(); end
    next(); stat_clr = 1; set_lu(); push_exp();
    next(); push_exp();

    // reset while mult/div is busy, then no done pulse after release
    next(); id_md_start = 1; push_exp();
    next(); push_exp();
    next(); resetn = 0; md_s = -1000; cnt = 0; push_exp();
    next(); push_exp();
    next(); resetn = 1; push_exp();
    repeat (6) begin next(); push_exp(); end

    // randomized traffic
    repeat (600) begin next(); rand_inputs(); push_exp(); end

    next(); push_exp();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised hazard, forwarding and stall controller for the 5-stage pipelined CPU. It generalises ID-stage forwarding and load-use stall generation and adds:
- a configurable register-address width;
- tracking of a multi-cycle multiply/divide unit;
- a memory-wait pipeline freeze;
- an optional taken-branch IF flush;
- a saturating stall-cycle performance counter.

It sits beside the ID-stage decoder and drives the PC / IF-ID write enables, ID/EX bubble insertion and the operand-forwarding muxes.

Parameters:
REG_AW, 5, register address width
MD_LAT, 4, multiply/divide latency in cycles (>=1)
CNT_W, 16, stall-cycle counter width
DELAY_SLOT, 1, 1 = branch delay slot (no flush), 0 = flush IF/ID on taken branch

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
id_rs, id_rt  in  REG_AW  ID-stage source register numbers
id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
e_rn, m_rn  in  REG_AW  destination register in EX / MEM
e_wreg, m_wreg  in  1  EX / MEM instruction writes a register
e_m2reg, m_m2reg  in  1  EX / MEM instruction is a load
m_mem  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
id_md_start  in  1  ID instruction issues mult/div
id_md_read  in  1  ID instruction reads HI/LO
id_branch_taken  in  1  ID branch/jump redirects PC
stat_clr  in  1  synchronous clear of stall counter
fwda, fwdb  out  2  forward select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
wpcir  out  1  PC and IF/ID write enable
bubble  out  1  force ID/EX control to NOP
freeze  out  1  hold every pipeline register
flush_if  out  1  replace IF/ID with NOP
md_busy  out  1  mult/div unit in BUSY state
md_done  out  1  one-cycle pulse, result available
stall_cycles  out  CNT_W  saturating count of cycles with wpcir=0

Behaviour:
- Forwarding (combinational), evaluated independently for the A operand (id_rs) and the B operand (id_rt):
  - EX match = e_wreg & e_rn!=0 & e_rn==src & ~e_m2reg -> 01.
  - Otherwise MEM match = m_wreg & m_rn!=0 & m_rn==src -> 10 if ~m_m2reg, 11 if m_m2reg.
  - Otherwise 00.
  - EX has priority over MEM. Register 0 is never forwarded. Forwarding is independent of id_use_*.
- lu_stall = e_wreg & e_m2reg & e_rn!=0 & ((id_use_rs & e_rn==id_rs) | (id_use_rt & e_rn==id_rt)).
- freeze = m_mem & ~dmem_ready. Highest priority; all pipeline registers hold, including the MD request path.
- md_stall = md_busy & (id_md_start | id_md_read).
- wpcir = ~(freeze | lu_stall | md_stall).
- bubble = ~freeze & (lu_stall | md_stall).
- issue = wpcir (the ID instruction advances this cycle).
- flush_if = (DELAY_SLOT==0) & id_branch_taken & issue. No flush while stalled; the branch re-resolves.
- MD state machine, states IDLE and BUSY, with a down-counter of width clog2(MD_LAT)+1:
  - IDLE: if id_md_start & issue, load count=MD_LAT-1 and go to BUSY.
  - BUSY: count decrements every cycle, including freeze cycles. When count==0, go to IDLE and set md_done=1 for exactly the next cycle.
  - md_busy = (state==BUSY).
  - A start accepted at cycle t gives BUSY over t+1..t+MD_LAT and md_done at t+MD_LAT+1. A waiting reader or a new start issues in that same cycle.
  - A start issued in the md_done cycle is accepted (the state is IDLE).
- stall_cycles: +1 on each rising edge where wpcir==0. Saturates at all-ones. stat_clr sets it to 0 and has priority over increment.
- Reset (asynchronous, resetn=0): state=IDLE, count=0, md_done=0, stall_cycles=0. The combinational outputs follow their inputs, with md_busy=0 so md_stall=0.
- Reset deasserted mid-operation: any in-flight MD operation is abandoned and no md_done pulse is produced.
- Simultaneous lu_stall and md_stall: a single bubble; the counter increments by 1.

Test Plan:
1. Forward priority: id_rs=3, e_rn=3, e_wreg=1, e_m2reg=0 and m_rn=3, m_wreg=1 -> fwda=01. Drop e_wreg -> fwda=10. Set m_m2reg=1 -> fwda=11. Set rs=0 in all stages -> fwda=00.
2. Load-use: e_rn=5, e_wreg=1, e_m2reg=1, id_rt=5, id_use_rt=1 -> wpcir=0, bubble=1, stall_cycles +1. Same with id_use_rt=0 -> wpcir=1.
3. MD latency, MD_LAT=4: id_md_start at cycle 0 -> md_busy=1 over cycles 1-4. id_md_read held from cycle 2 -> wpcir=0 over cycles 2-4. Cycle 5: md_done=1, wpcir=1. Cycle 6: md_done=0.
4. Freeze: m_mem=1, dmem_ready=0 for 3 cycles during a load-use hazard -> freeze=1, bubble=0, wpcir=0, stall_cycles +3. MD counter still advances.
5. Flush, DELAY_SLOT=0: id_branch_taken=1 with no hazard -> flush_if=1. Same with lu_stall active -> flush_if=0. With DELAY_SLOT=1 -> flush_if always 0.
6. Counter and reset: CNT_W=4, hold wpcir=0 for 20 cycles -> stall_cycles=15. stat_clr -> 0. resetn low while BUSY -> md_busy=0 immediately, and no md_done after release.
